// File: rtl/lfsr_prbs_checker.sv
// PRBS checker for the 32-bit Galois LFSR generator: self-synchronises a local
// LFSR to the incoming word stream, then flags and counts mismatching words.
module lfsr_prbs_checker #(
   parameter logic [31:0] TAPS       = 32'h8020_0003,
   parameter int unsigned LOCK_CNT   = 8,
   parameter int unsigned UNLOCK_CNT = 4,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic             lock_lost,
   output logic             stuck_zero
);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_VERIFY,
      S_LOCKED
   } state_t;

   localparam logic [7:0]       LOCK_CNT_8   = LOCK_CNT[7:0];
   localparam logic [7:0]       UNLOCK_CNT_8 = UNLOCK_CNT[7:0];
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_pred, w_pred_nxt;
   logic [7:0]       r_run_cnt, w_run_nxt, w_run_inc;
   logic             r_locked, w_locked_nxt;
   logic             r_err_pulse, w_err_pulse_nxt;
   logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
   logic             r_lock_lost, w_lock_lost_nxt;
   logic             r_stuck_zero, w_stuck_zero_nxt;
   logic             w_match, w_zero, w_err_inc;

   function automatic logic [31:0] step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
   endfunction

   assign w_match   = (in_data == r_pred);
   assign w_zero    = (in_data == 32'h0);
   assign w_run_inc = r_run_cnt + 8'd1;

   // NOTE: every next-state signal gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_pred_nxt      = r_pred;
      w_run_nxt       = r_run_cnt;
      w_locked_nxt    = r_locked;
      w_err_pulse_nxt = 1'b0;
      w_lock_lost_nxt = 1'b0;
      w_err_inc       = 1'b0;

      if (in_valid) begin
         case (r_state)
            S_SEARCH: begin
               if (!w_zero) begin
                  w_pred_nxt  = step(in_data);
                  w_run_nxt   = 8'd0;
                  w_state_nxt = S_VERIFY;
               end
            end
            S_VERIFY: begin
               if (w_match) begin
                  w_pred_nxt = step(r_pred);
                  w_run_nxt  = w_run_inc;
                  if (w_run_inc == LOCK_CNT_8) begin
                     w_state_nxt  = S_LOCKED;
                     w_locked_nxt = 1'b1;
                     w_run_nxt    = 8'd0;
                  end
               end else if (!w_zero) begin
                  w_pred_nxt = step(in_data);
                  w_run_nxt  = 8'd0;
               end else begin
                  w_state_nxt = S_SEARCH;
                  w_run_nxt   = 8'd0;
               end
            end
            S_LOCKED: begin
               // Free-running prediction: one corrupted word costs exactly one error.
               w_pred_nxt = step(r_pred);
               if (w_match) begin
                  w_run_nxt = 8'd0;
               end else begin
                  w_err_pulse_nxt = 1'b1;
                  w_err_inc       = 1'b1;
                  w_run_nxt       = w_run_inc;
                  if (w_run_inc == UNLOCK_CNT_8) begin
                     w_state_nxt     = S_SEARCH;
                     w_locked_nxt    = 1'b0;
                     w_lock_lost_nxt = 1'b1;
                     w_run_nxt       = 8'd0;
                  end
               end
            end
            default: begin
               w_state_nxt  = S_SEARCH;
               w_run_nxt    = 8'd0;
               w_locked_nxt = 1'b0;
            end
         endcase
      end

      w_err_cnt_nxt = r_err_cnt;
      if (clr_cnt) begin
         w_err_cnt_nxt = '0;
      end else if (w_err_inc && (r_err_cnt != CNT_MAX)) begin
         w_err_cnt_nxt = r_err_cnt + 1'b1;
      end

      w_stuck_zero_nxt = r_stuck_zero;
      if (in_valid && w_zero) begin
         w_stuck_zero_nxt = 1'b1;
      end else if (clr_cnt) begin
         w_stuck_zero_nxt = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_SEARCH;
         r_pred       <= 32'h0;
         r_run_cnt    <= 8'd0;
         r_locked     <= 1'b0;
         r_err_pulse  <= 1'b0;
         r_err_cnt    <= '0;
         r_lock_lost  <= 1'b0;
         r_stuck_zero <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pred       <= w_pred_nxt;
         r_run_cnt    <= w_run_nxt;
         r_locked     <= w_locked_nxt;
         r_err_pulse  <= w_err_pulse_nxt;
         r_err_cnt    <= w_err_cnt_nxt;
         r_lock_lost  <= w_lock_lost_nxt;
         r_stuck_zero <= w_stuck_zero_nxt;
      end
   end

   assign locked     = r_locked;
   assign err_pulse  = r_err_pulse;
   assign err_cnt    = r_err_cnt;
   assign lock_lost  = r_lock_lost;
   assign stuck_zero = r_stuck_zero;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: vector table for lock/error/unlock,
// plus hand-written sequences for long runs, VERIFY reseed, gaps and saturation.
module tb_lfsr_prbs_checker;

   localparam logic [31:0] TAPS = 32'h8020_0003;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_clr;
   logic        locked, err_pulse, lock_lost, stuck_zero;
   logic [15:0] err_cnt;

   logic        s_rst_n;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_clr;
   logic        s_locked, s_err_pulse, s_lock_lost, s_stuck_zero;
   logic [3:0]  s_err_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lfsr_prbs_checker #(.TAPS(TAPS), .LOCK_CNT(8), .UNLOCK_CNT(4), .CNT_W(16)) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .clr_cnt   (in_clr),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt),
      .lock_lost (lock_lost),
      .stuck_zero(stuck_zero)
   );

   lfsr_prbs_checker #(.TAPS(TAPS), .LOCK_CNT(8), .UNLOCK_CNT(4), .CNT_W(4)) u_sat (
      .clk       (clk),
      .reset     (s_rst_n),
      .in_valid  (s_valid),
      .in_data   (s_data),
      .clr_cnt   (s_clr),
      .locked    (s_locked),
      .err_pulse (s_err_pulse),
      .err_cnt   (s_err_cnt),
      .lock_lost (s_lock_lost),
      .stuck_zero(s_stuck_zero)
   );

   typedef struct {
      logic        valid;
      logic [31:0] mask;
      logic        clr;
      logic        exp_locked;
      logic        exp_ep;
      logic [15:0] exp_cnt;
      logic        exp_ll;
      logic        exp_sz;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [31:0] gen_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
   endfunction

   // Packed view {locked, err_pulse, err_cnt, lock_lost, stuck_zero}.
   function automatic logic [31:0] pack(input logic l, input logic e, input logic [15:0] c,
                                        input logic ll, input logic sz);
      return {12'd0, l, e, c, ll, sz};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (locked,ep,cnt,ll,sz packed)", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic c);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      in_clr   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_s(input logic v, input logic [31:0] d, input logic c);
      @(negedge clk);
      s_valid = v;
      s_data  = d;
      s_clr   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_main();
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 32'h0;
      in_clr   = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push(input logic v, input logic [31:0] m, input logic c, input logic l,
                       input logic e, input logic [15:0] cnt, input logic ll, input logic sz);
      tbl.push_back('{v, m, c, l, e, cnt, ll, sz});
   endtask

   initial begin : main
      logic [31:0] gen;
      logic [31:0] word;
      int          bad_ep;
      int          bad_lock;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 32'h0;
      in_clr   = 1'b0;
      s_rst_n  = 1'b0;
      s_valid  = 1'b0;
      s_data   = 32'h0;
      s_clr    = 1'b0;
      #12;
      check("reset_state", pack(locked, err_pulse, err_cnt, lock_lost, stuck_zero),
            pack(1'b0, 1'b0, 16'd0, 1'b0, 1'b0));

      // Clean stream from seed 1: lock after seed + 8 words, no errors over 1000 words.
      reset_main();
      gen      = 32'h1;
      bad_ep   = 0;
      bad_lock = 0;
      for (int k = 0; k < 1000; k++) begin
         drive(1'b1, gen, 1'b0);
         gen = gen_step(gen);
         if (k == 1) check("stream_word2", in_data, 32'h8020_0003);
         if (k == 7) check("clean_pre_lock", {31'd0, locked}, 32'd0);
         if (k == 8) check("clean_lock", {31'd0, locked}, 32'd1);
         if (k > 8 && !locked) bad_lock++;
         if (err_pulse) bad_ep++;
      end
      check("clean_err_cnt", {16'd0, err_cnt}, 32'd0);
      check("clean_no_pulse", bad_ep, 0);
      check("clean_stays_locked", bad_lock, 0);

      // Vector table: lock, single error, idle, clr vs error, 4-error unlock, relock.
      for (int i = 0; i < 8; i++) push(1, 32'h0, 0, 0, 0, 16'd0, 0, 0);
      push(1, 32'h0,         0, 1, 0, 16'd0, 0, 0);
      push(1, 32'h0,         0, 1, 0, 16'd0, 0, 0);
      push(1, 32'h0,         0, 1, 0, 16'd0, 0, 0);
      push(1, 32'h0000_0020, 0, 1, 1, 16'd1, 0, 0);
      push(0, 32'h0,         0, 1, 0, 16'd1, 0, 0);
      push(1, 32'h0,         0, 1, 0, 16'd1, 0, 0);
      push(1, 32'h0,         0, 1, 0, 16'd1, 0, 0);
      push(1, 32'h0F00_0000, 1, 1, 1, 16'd0, 0, 0);
      push(1, 32'h0,         0, 1, 0, 16'd0, 0, 0);
      push(1, 32'hFFFF_0000, 0, 1, 1, 16'd1, 0, 0);
      push(1, 32'hFFFF_0000, 0, 1, 1, 16'd2, 0, 0);
      push(1, 32'hFFFF_0000, 0, 1, 1, 16'd3, 0, 0);
      push(1, 32'hFFFF_0000, 0, 0, 1, 16'd4, 1, 0);
      push(0, 32'h0,         0, 0, 0, 16'd4, 0, 0);
      for (int i = 0; i < 8; i++) push(1, 32'h0, 0, 0, 0, 16'd4, 0, 0);
      push(1, 32'h0,         0, 1, 0, 16'd4, 0, 0);

      reset_main();
      gen = 32'h1;
      foreach (tbl[i]) begin
         word = tbl[i].valid ? (gen ^ tbl[i].mask) : 32'hDEAD_BEEF;
         drive(tbl[i].valid, word, tbl[i].clr);
         if (tbl[i].valid) gen = gen_step(gen);
         check($sformatf("vec%0d", i), pack(locked, err_pulse, err_cnt, lock_lost, stuck_zero),
               pack(tbl[i].exp_locked, tbl[i].exp_ep, tbl[i].exp_cnt, tbl[i].exp_ll,
                    tbl[i].exp_sz));
      end

      // Corrupted word at VERIFY match 5: reseed, no error, lock 8 matches later.
      reset_main();
      gen    = 32'h1;
      bad_ep = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, gen, 1'b0);
         gen = gen_step(gen);
      end
      drive(1'b1, gen ^ 32'h0000_0100, 1'b0);
      gen = gen_step(gen);
      if (err_pulse) bad_ep++;
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, gen, 1'b0);
         gen = gen_step(gen);
         if (err_pulse) bad_ep++;
         if (k == 7) check("verify_reseed_pre", {31'd0, locked}, 32'd0);
      end
      check("verify_reseed_lock", {31'd0, locked}, 32'd1);
      check("verify_no_err", {bad_ep[15:0], err_cnt}, 32'd0);

      // Alternating valid/idle: idle garbage ignored, lock after 9 valid words.
      reset_main();
      gen    = 32'h1;
      bad_ep = 0;
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, gen, 1'b0);
         gen = gen_step(gen);
         if (k == 7) check("gap_pre_lock", {31'd0, locked}, 32'd0);
         drive(1'b0, 32'hDEAD_BEEF, 1'b0);
         if (err_pulse) bad_ep++;
      end
      check("gap_lock", {31'd0, locked}, 32'd1);
      check("gap_no_err", {bad_ep[15:0], err_cnt}, 32'd0);
      drive(1'b1, 32'h0, 1'b0);
      gen = gen_step(gen);
      check("zero_word", pack(locked, err_pulse, err_cnt, lock_lost, stuck_zero),
            pack(1'b1, 1'b1, 16'd1, 1'b0, 1'b1));
      drive(1'b1, gen, 1'b1);
      gen = gen_step(gen);
      check("clr_stuck", pack(locked, err_pulse, err_cnt, lock_lost, stuck_zero),
            pack(1'b1, 1'b0, 16'd0, 1'b0, 1'b0));
      drive(1'b1, 32'h0, 1'b1);
      gen = gen_step(gen);
      check("zero_and_clr", pack(locked, err_pulse, err_cnt, lock_lost, stuck_zero),
            pack(1'b1, 1'b1, 16'd0, 1'b0, 1'b1));
      drive(1'b1, gen, 1'b0);
      gen = gen_step(gen);
      check("stuck_sticky", pack(locked, err_pulse, err_cnt, lock_lost, stuck_zero),
            pack(1'b1, 1'b0, 16'd0, 1'b0, 1'b1));

      // Narrow counter saturation, then asynchronous reset while LOCKED.
      @(negedge clk);
      s_rst_n = 1'b1;
      gen     = 32'h1;
      for (int k = 0; k < 9; k++) begin
         drive_s(1'b1, gen, 1'b0);
         gen = gen_step(gen);
      end
      check("sat_lock", {31'd0, s_locked}, 32'd1);
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < 3; k++) begin
            drive_s(1'b1, gen ^ 32'h0000_0F00, 1'b0);
            gen = gen_step(gen);
         end
         drive_s(1'b1, gen, 1'b0);
         gen = gen_step(gen);
         if (b == 4) check("sat_cnt15", {28'd0, s_err_cnt}, 32'd15);
      end
      check("sat_hold", {27'd0, s_locked, s_err_cnt}, {27'd0, 1'b1, 4'd15});
      drive_s(1'b1, 32'h0, 1'b0);
      gen = gen_step(gen);
      check("sat_pre_reset", {29'd0, s_locked, s_err_pulse, s_stuck_zero}, 32'd7);
      @(negedge clk);
      #2;
      s_rst_n = 1'b0;
      #1;
      check("async_reset", {24'd0, s_locked, s_err_pulse, s_err_cnt, s_lock_lost, s_stuck_zero},
            32'd0);
      @(negedge clk);
      s_rst_n = 1'b1;
      drive_s(1'b1, gen, 1'b0);
      gen = gen_step(gen);
      drive_s(1'b1, gen, 1'b0);
      check("no_instant_relock", {27'd0, s_locked, s_err_cnt}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
